prompt_sequence_decoder: RTL

//  Reader for the 64-bit run-length prompt string built by the input-side string register.

---
 rtl/prompt_sequence_decoder_pkg.sv | 26 ++
 rtl/prompt_sequence_decoder_if.sv | 24 ++
 rtl/prompt_sequence_decoder_hold_timer.sv | 41 ++++
 rtl/prompt_sequence_decoder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/prompt_sequence_decoder_pkg.sv
// rtl/prompt_sequence_decoder_pkg.sv - shared types and constants for the prompt sequence decoder
package prompt_sequence_decoder_pkg;

    localparam int STRING_W = 64;
    localparam int MAX_RUN  = 4;

    localparam logic [2:0] PROMPT_NONE   = 3'd0;
    localparam logic [2:0] PROMPT_TOGGLE = 3'd1;
    localparam logic [2:0] PROMPT_PUSH   = 3'd2;
    localparam logic [2:0] PROMPT_MIC    = 3'd3;
    localparam logic [2:0] PROMPT_MOUSE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEEK  = 3'd1,
        COUNT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/prompt_sequence_decoder_if.sv
// rtl/prompt_sequence_decoder_if.sv - string/control inputs and prompt outputs of the decoder
interface prompt_sequence_decoder_if;
    import prompt_sequence_decoder_pkg::*;

    logic [STRING_W-1:0] prompt_str;
    logic                load;
    logic                abort;
    logic [2:0]          prompt;
    logic                sym_strobe;
    logic                busy;
    logic                done;
    logic                error;
    logic [4:0]          symbol_count;

    modport master (
        output prompt_str, load, abort,
        input  prompt, sym_strobe, busy, done, error, symbol_count
    );

    modport slave (
        input  prompt_str, load, abort,
        output prompt, sym_strobe, busy, done, error, symbol_count
    );
endinterface

// File: rtl/prompt_sequence_decoder_hold_timer.sv
// rtl/prompt_sequence_decoder_hold_timer.sv - loadable down-counter timing the HOLD and GAP phases
module prompt_hold_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count_value,
    output logic             expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // Loading value-1 makes expired fire on the value-th cycle after start.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = count_value - CNT_W'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign expired = active_q && (cnt_q == '0);
endmodule

// File: rtl/prompt_sequence_decoder.sv
// rtl/prompt_sequence_decoder.sv - scans a run-length prompt string MSB-first and replays timed prompt codes
module prompt_sequence_decoder
    import prompt_sequence_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int CNT_W       = 26
) (
    input  logic                          clock,
    input  logic                          reset,
    prompt_sequence_decoder_if.slave      bus
);
    localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_V  = CNT_W'(GAP_CYCLES);

    state_t              state_q, state_d;
    logic [STRING_W-1:0] sr_q, sr_d;
    logic [6:0]          bits_left_q, bits_left_d;
    logic [2:0]          run_q, run_d;
    logic [4:0]          count_q, count_d;
    logic                error_q, error_d;
    logic                strobe_q, strobe_d;
    logic                tmr_start;
    logic                tmr_expired;
    logic [CNT_W-1:0]    tmr_value;

    // Only COUNT starts a hold; every other start is the gap following a hold.
    assign tmr_value = (state_q == COUNT) ? HOLD_V : GAP_V;

    prompt_hold_timer #(.CNT_W(CNT_W)) u_timer (
        .clock       (clock),
        .reset       (reset),
        .start       (tmr_start),
        .count_value (tmr_value),
        .expired     (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bits_left_d = bits_left_q;
        run_d       = run_q;
        count_d     = count_q;
        error_d     = error_q;
        strobe_d    = 1'b0;
        tmr_start   = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        state_d     = SEEK;
                        sr_d        = bus.prompt_str;
                        bits_left_d = 7'd64;
                        run_d       = 3'd0;
                        count_d     = 5'd0;
                        error_d     = 1'b0;
                    end
                end
                SEEK: begin
                    sr_d        = {sr_q[STRING_W-2:0], 1'b0};
                    bits_left_d = bits_left_q - 7'd1;
                    if (sr_q[STRING_W-1]) begin
                        run_d = 3'd1;
                        if (bits_left_d == 7'd0) begin
                            error_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = COUNT;
                        end
                    end else if (bits_left_d == 7'd0) begin
                        state_d = DONE;
                    end
                end
                COUNT: begin
                    sr_d        = {sr_q[STRING_W-2:0], 1'b0};
                    bits_left_d = bits_left_q - 7'd1;
                    if (sr_q[STRING_W-1]) begin
                        if (run_q == 3'(MAX_RUN) || bits_left_d == 7'd0) begin
                            error_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            run_d = run_q + 3'd1;
                        end
                    end else begin
                        state_d   = HOLD;
                        tmr_start = 1'b1;
                        count_d   = sat_inc5(count_q);
                        strobe_d  = 1'b1;
                    end
                end
                HOLD: begin
                    if (tmr_expired) begin
                        state_d   = GAP;
                        tmr_start = 1'b1;
                    end
                end
                GAP: begin
                    if (tmr_expired) begin
                        state_d = (bits_left_q == 7'd0) ? DONE : SEEK;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bits_left_q <= 7'd0;
            run_q       <= 3'd0;
            count_q     <= 5'd0;
            error_q     <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bits_left_q <= bits_left_d;
            run_q       <= run_d;
            count_q     <= count_d;
            error_q     <= error_d;
            strobe_q    <= strobe_d;
        end
    end

    assign bus.prompt       = (state_q == HOLD) ? run_q : PROMPT_NONE;
    assign bus.sym_strobe   = strobe_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.error        = error_q;
    assign bus.symbol_count = count_q;
endmodule
